// File: rtl/convert_2d_to_1d_packer.sv
// Streaming packer: gathers COLS elements of BIT_WIDTH bits (column 0 first) into one flat word.
// Optional column counter output out_cols is enabled by defining CONVERT_2D_TO_1D_PACKER_COUNT_EN.
module convert_2d_to_1d_packer #(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIT_WIDTH-1:0]      in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*BIT_WIDTH-1:0] out
`ifdef CONVERT_2D_TO_1D_PACKER_COUNT_EN
  ,
  output logic [$clog2(COLS+1)-1:0] out_cols
`endif
);

  localparam int W  = COLS * BIT_WIDTH;
  localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  word_buf;
  logic [W-1:0]  fill_word;
  logic [W-1:0]  first_word;
  logic          accept;
  logic          transfer;
  logic          closes_word;

  // Stall only while a finished word is waiting and the consumer is not taking it.
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign transfer    = out_valid && out_ready;
  assign closes_word = (int'(idx) == COLS - 1) || in_last;

  // NOTE: every always_comb output gets a full default before any partial update, so no latch is inferred.
  always_comb begin
    fill_word = word_buf;
    fill_word[int'(idx)*BIT_WIDTH +: BIT_WIDTH] = in_data;
    first_word = '0;
    first_word[BIT_WIDTH-1:0] = in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      out_valid <= 1'b0;
      idx       <= '0;
      // NOTE: the assembly buffer is reset too, so a word cut short by reset leaves no stale columns.
      word_buf  <= '0;
      out       <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (closes_word) begin
              out       <= fill_word;
              word_buf  <= '0;
              idx       <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              word_buf <= fill_word;
              idx      <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (transfer) begin
            if (accept && (COLS == 1 || in_last)) begin
              // Single-element word completes on the same edge the previous one leaves.
              out <= first_word;
            end else if (accept) begin
              word_buf  <= first_word;
              idx       <= IW'(1);
              state     <= FILL;
              out_valid <= 1'b0;
              out       <= '0;
            end else begin
              state     <= FILL;
              out_valid <= 1'b0;
              out       <= '0;
            end
          end
        end
      endcase
    end
  end

`ifdef CONVERT_2D_TO_1D_PACKER_COUNT_EN
  localparam int CW = $clog2(COLS + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cols <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept && closes_word) out_cols <= CW'(idx) + CW'(1);
        end
        HOLD: begin
          if (transfer) out_cols <= (accept && (COLS == 1 || in_last)) ? CW'(1) : '0;
        end
      endcase
    end
  end
`else
  // Column count is not tracked in this build.
`endif

endmodule

// File: tb/tb_convert_2d_to_1d_packer.sv
// Directed bench for convert_2d_to_1d_packer: queue-based word model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_convert_2d_to_1d_packer;

  localparam int BW = 4;
  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, out_valid, out_ready;
  logic [BW-1:0] in_data;
  logic [NC*BW-1:0] out;

  logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out;

`ifdef CONVERT_2D_TO_1D_PACKER_COUNT_EN
  logic [$clog2(NC+1)-1:0] out_cols;
  logic [0:0]              b_out_cols;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  convert_2d_to_1d_packer #(.BIT_WIDTH(BW), .COLS(NC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef CONVERT_2D_TO_1D_PACKER_COUNT_EN
    , .out_cols(out_cols)
`endif
  );

  convert_2d_to_1d_packer #(.BIT_WIDTH(8), .COLS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
`ifdef CONVERT_2D_TO_1D_PACKER_COUNT_EN
    , .out_cols(b_out_cols)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-level model: elements queue up until COLS arrive or in_last, then form a held word.
  logic [BW-1:0]    m_cur[$];
  logic [NC*BW-1:0] m_word  = '0;
  logic             m_valid = 1'b0;
  int               m_cnt   = 0;
  logic             m_acc, m_xfer;

  function automatic logic [NC*BW-1:0] pack(input logic [BW-1:0] q[$]);
    logic [NC*BW-1:0] w = '0;
    for (int i = 0; i < q.size(); i++) w[i*BW +: BW] = q[i];
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_cnt   = 0;
    end else begin
      m_xfer = m_valid && out_ready;
      m_acc  = in_valid && (!m_valid || out_ready);
      if (m_xfer) m_valid = 1'b0;
      if (m_acc) begin
        m_cur.push_back(in_data);
        if (m_cur.size() == NC || in_last) begin
          m_word  = pack(m_cur);
          m_cnt   = m_cur.size();
          m_valid = 1'b1;
          m_cur.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_out_valid", out_valid, m_valid);
    check("model_out", out, m_valid ? m_word : '0);
    check("model_in_ready", in_ready, !m_valid || out_ready);
`ifdef CONVERT_2D_TO_1D_PACKER_COUNT_EN
    check("model_out_cols", out_cols, m_valid ? m_cnt : 0);
`endif
  end

  logic [31:0] exp3[3];

  initial begin
    exp3[0] = 32'h76543210;
    exp3[1] = 32'hFEDCBA98;
    exp3[2] = 32'h76543210;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // 1: reset state, then one full word at full rate
    check("reset_out", out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = BW'(i + 1);
      tick();
    end
    check("t1_word", out, 32'h87654321);
    check("t1_out_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("t1_drained", out_valid, 0);
    check("t1_cleared", out, 0);

    // 2: back-pressure holds the word; pending element enters column 0 on release
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = BW'(i + 1);
      tick();
    end
    in_data = 4'hA;
    repeat (5) begin
      check("t2_in_ready_low", in_ready, 0);
      check("t2_word_stable", out, 32'h87654321);
      tick();
    end
    out_ready = 1'b1;
    #1 check("t2_in_ready_release", in_ready, 1);
    tick();
    check("t2_after_transfer_valid", out_valid, 0);
    for (int i = 0; i < 7; i++) begin
      in_data = BW'(i + 1);
      tick();
    end
    check("t2_word_with_a", out, 32'h7654321A);
    in_valid = 1'b0;
    tick();

    // 3: continuous stream, no bubbles
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1; in_data = BW'(i % 16);
      check("t3_in_ready", in_ready, 1);
      tick();
      if (i % 8 == 7) check("t3_word", out, exp3[i/8]);
    end
    in_valid = 1'b0;
    tick();

    // 4: early close, then a fresh word from column 0
    in_valid = 1'b1; in_data = 4'h5; tick();
    in_data = 4'h6; tick();
    in_data = 4'h7; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_early_word", out, 32'h00000765);
`ifdef CONVERT_2D_TO_1D_PACKER_COUNT_EN
    check("t4_out_cols", out_cols, 3);
`endif
    tick();
    in_valid = 1'b1; in_data = 4'h9; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_next_word", out, 32'h00000009);
    tick();

    // 5: async reset mid-word and mid-HOLD
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'hF;
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("t5_rst_fill_out", out, 0);
    check("t5_rst_fill_valid", out_valid, 0);
    #2 rst = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    in_data = 4'h3; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("t5_no_stale", out, 32'h00000321);
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = BW'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    check("t5_hold_before_rst", out_valid, 1);
    #2 rst = 1'b1;
    #1 check("t5_rst_hold_out", out, 0);
    check("t5_rst_hold_valid", out_valid, 0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 4'h2; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("t5_after_rst_word", out, 32'h00000002);
    tick();

    // 6: single-column packer, one word per element
    b_in_valid = 1'b1; b_in_data = 8'hAA;
    tick();
    check("t6_word_aa", b_out, 8'hAA);
    check("t6_valid_aa", b_out_valid, 1);
    b_in_data = 8'h55;
    check("t6_in_ready", b_in_ready, 1);
    tick();
    check("t6_word_55", b_out, 8'h55);
    check("t6_valid_55", b_out_valid, 1);
`ifdef CONVERT_2D_TO_1D_PACKER_COUNT_EN
    check("t6_out_cols", b_out_cols, 1);
`endif
    b_in_valid = 1'b0;
    tick();
    check("t6_drained", b_out_valid, 0);
    check("t6_cleared", b_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
